// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
//   Moore control FSM for the sequence-memory game. It runs beside fluxo_dados.
//   Each round it clears the address counter and the play register, then waits
//   for a play. It registers the play, compares it with the ROM word and moves
//   to the next address. The round ends in a hit, miss or timeout state. A
//   final state holds until iniciar starts a new round.
//
// Parameters
//   TIMEOUT  clock cycles allowed in espera_jogada before a timeout (0 = off)
//   TW       width of the timeout counter (at least 1)
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   iniciar      in   start request (level)
//   jogada_feita in   one-cycle play pulse from the datapath edge detector
//   igual        in   ROM word equals the registered play
//   fimC         in   address counter at its last word
//   zeraC        out  clear the address counter
//   contaC       out  increment the address counter
//   zeraR        out  clear the play register and the edge detector
//   registrarR   out  load the switches into the play register
//   pronto       out  round finished
//   acertou      out  full sequence matched
//   errou        out  mismatch detected
//   timeout      out  no play within TIMEOUT cycles
//   db_estado    out  current state code, for debug
// -----------------------------------------------------------------------------
module unidade_controle #(
  parameter int TIMEOUT = 5000,
  parameter int TW      = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registrarR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h4,
    COMPARACAO    = 4'h5,
    PROXIMO       = 4'h6,
    FIM_ACERTOU   = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERROU     = 4'hE
  } state_t;

  // The last timer value before expiry. It is unused when TIMEOUT is 0.
  localparam int unsigned   LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TW-1:0] T_LIM = TW'(LIMIT);

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic          w_expira;

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= INICIAL;
    else       r_state <= w_next;
  end

  // The timer counts only while waiting for a play. Every other state clears
  // it, so each new wait starts from zero. It saturates rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == ESPERA_JOGADA) begin
      if (r_timer != '1) r_timer <= r_timer + TW'(1);
    end else begin
      r_timer <= '0;
    end
  end

  assign w_expira = (TIMEOUT != 0) && (r_timer == T_LIM);

  // NOTE: w_next gets a default before the case. Any path that does not assign
  // it then cannot infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      INICIAL:       if (iniciar) w_next = PREPARACAO;
      PREPARACAO:    w_next = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A play arriving in the expiry cycle takes priority over the timeout.
        if (jogada_feita)  w_next = REGISTRA;
        else if (w_expira) w_next = FIM_TIMEOUT;
      end
      REGISTRA:      w_next = COMPARACAO;
      COMPARACAO: begin
        // A mismatch at the last address is still a miss.
        if (!igual)    w_next = FIM_ERROU;
        else if (fimC) w_next = FIM_ACERTOU;
        else           w_next = PROXIMO;
      end
      PROXIMO:       w_next = ESPERA_JOGADA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:   if (iniciar) w_next = PREPARACAO;
      default:       w_next = INICIAL;
    endcase
  end

  // Moore outputs: these decode the registered state only.
  always_comb begin
    zeraC      = 1'b0;
    contaC     = 1'b0;
    zeraR      = 1'b0;
    registrarR = 1'b0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    timeout    = 1'b0;
    case (r_state)
      PREPARACAO:  begin zeraC = 1'b1; zeraR = 1'b1; end
      REGISTRA:    registrarR = 1'b1;
      PROXIMO:     contaC = 1'b1;
      FIM_ACERTOU: begin pronto = 1'b1; acertou = 1'b1; end
      FIM_ERROU:   begin pronto = 1'b1; errou   = 1'b1; end
      FIM_TIMEOUT: begin pronto = 1'b1; timeout = 1'b1; end
      default:     ;
    endcase
  end

  assign db_estado = r_state;

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore FSM that sequences the sequence-memory game datapath.
- Clears the address counter and the play register, then waits for a play.
- Registers the switches, compares them with the ROM word and advances the address.
- Ends in a hit, miss or timeout state; sits beside fluxo_dados and drives zeraC, contaC, zeraR and registrarR.

Parameters:
- TIMEOUT, 5000: clock cycles allowed in espera_jogada before a timeout. 0 disables the timeout.
- TW, $clog2(TIMEOUT+1) (minimum 1): width of the internal timeout counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- iniciar  input  1  start request; level, sampled each cycle.
- jogada_feita  input  1  one-cycle play pulse from the datapath edge detector.
- igual  input  1  comparator result: ROM word equals the registered play.
- fimC  input  1  counter rco; high when the address is 15.
- zeraC  output  1  clear the address counter.
- contaC  output  1  increment the address counter.
- zeraR  output  1  clear the play register and the edge detector.
- registrarR  output  1  load the switches into the play register.
- pronto  output  1  round finished.
- acertou  output  1  full sequence matched.
- errou  output  1  mismatch detected.
- timeout  output  1  no play within TIMEOUT cycles.
- db_estado  output  4  current state code, for debug.

Behaviour:
- One clock domain.
- Reset is asynchronous and active-high, port name reset. Assertion forces state inicial immediately, including mid-round, and clears the timer.
- All outputs are registered-state decodes (Moore). None depend combinationally on inputs.
- State encoding (db_estado):
  - inicial=0x0
  - preparacao=0x1
  - espera_jogada=0x2
  - registra=0x4
  - comparacao=0x5
  - proximo=0x6
  - fim_acertou=0xA
  - fim_timeout=0xD
  - fim_errou=0xE
- Unused codes go to inicial on the next edge.
- Transitions:
  - inicial: stay until iniciar=1, then go to preparacao.
  - preparacao: go to espera_jogada unconditionally.
  - espera_jogada (evaluated in this priority order):
    1. jogada_feita=1 -> registra.
    2. else, TIMEOUT≠0 and timer==TIMEOUT-1 -> fim_timeout.
    3. else stay and increment the timer.
  - registra: go to comparacao.
  - comparacao:
    1. igual=0 -> fim_errou.
    2. else fimC=1 -> fim_acertou.
    3. else -> proximo.
  - proximo: go to espera_jogada.
  - fim_acertou, fim_errou, fim_timeout: hold until iniciar=1, then go to preparacao (new round, no pass through inicial).
- Output decode (all outputs are 0 except those listed for the state):
  - preparacao: zeraC=1, zeraR=1.
  - registra: registrarR=1.
  - proximo: contaC=1.
  - fim_acertou: pronto=1, acertou=1.
  - fim_errou: pronto=1, errou=1.
  - fim_timeout: pronto=1, timeout=1.
  - Exactly one of acertou, errou, timeout is high in a final state.
- Timer:
  - Cleared to 0 in every state other than espera_jogada, so each entry to espera_jogada starts at 0.
  - Saturates and never wraps.
- Latency:
  - iniciar to first espera_jogada: 2 edges.
  - jogada_feita to comparacao: 2 edges, so the register is loaded before igual is used.
  - After proximo, at least one espera_jogada cycle precedes the next comparacao. The sync ROM output is therefore valid when comparacao evaluates.
- Inputs are ignored outside the states that use them:
  - jogada_feita outside espera_jogada.
  - iniciar outside inicial and the final states.
- Simultaneous events:
  - jogada_feita in the same cycle as timer expiry: the play wins, go to registra.
  - igual=0 with fimC=1: errou wins.
- A full round of 16 correct plays ends in fim_acertou. The comparison at address 15 sees fimC=1.

Test Plan:
1. Reset check: assert reset mid-state (in registra) -> db_estado=0x0 asynchronously and all outputs 0; release, then iniciar=1 for one cycle -> db_estado 0x1 then 0x2, with zeraC=zeraR=1 only in 0x1.
2. Full hit run: drive 16 jogada_feita pulses with igual=1, fimC=1 only on the 16th compare -> exactly 15 contaC pulses, exactly 16 registrarR pulses, final db_estado=0xA, pronto=acertou=1.
3. Miss run: on the 3rd compare drive igual=0 -> db_estado=0xE, errou=1, pronto=1, contaC pulses=2; then iniciar=1 -> 0x1 and the counter cleared.
4. Timeout run: TIMEOUT=8, no play -> exactly 8 cycles in 0x2, then 0xD with timeout=1; repeat with jogada_feita in the 8th cycle -> 0x4, not a timeout.
5. Edge run: igual=0 with fimC=1 -> 0xE. A stray jogada_feita while in 0x6 or 0x0 causes no state change and no registrarR.
6. Timer restart: play at cycle 6 of 8, then idle after proximo -> the timeout occurs a full 8 cycles after re-entering 0x2.
